present_dec_ctrl: RTL and testbench
===================================

PRESENT_DEC_CTRL -- requirements
Module: present_dec_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 96: maximum cycles from core_load to core_done before an error result is reported.
REQ-002 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: upstream word valid.
REQ-005 SHALL have port in_ready, output, 1: word accepted when in_valid && in_ready.
REQ-006 SHALL have port in_data, input, 32: key/ciphertext word.
REQ-007 SHALL have port key_reuse, input, 1: sampled with the first word of a job; skips the key phase.
REQ-008 SHALL have ports core_load, core_ce (output, 1), core_key (output, 80) and core_idat (output, 64): drive the PRESENT decrypt core.
REQ-009 SHALL have ports core_done (input, 1) and core_odat (input, 64): decrypt core outputs.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 64) and out_err (output, 1): result handshake.

Function
REQ-011 SHALL implement states IDLE, KEY, DATA, LOAD, WAIT, OUT.
REQ-012 SHALL make in_ready high only in IDLE, KEY and DATA.
REQ-013 In IDLE, on an accepted word: if key_reuse=1 and key_loaded=1, SHALL store the word as idat[63:32] and go to DATA at index 1; otherwise SHALL store it as key[79:48] and go to KEY.
REQ-014 In KEY, SHALL store the 2nd word as key[47:16] and the 3rd word's bits [15:0] as key[15:0] (bits [31:16] ignored), set key_loaded, then go to DATA at index 0.
REQ-015 In DATA, SHALL store word 0 as idat[63:32] and word 1 as idat[31:0], then go to LOAD.
REQ-016 Throughout collection, SHALL hold state and all registers on any cycle with in_valid=0.
REQ-017 In LOAD, SHALL assert core_load=1 and core_ce=1 for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-018 SHALL hold core_key and core_idat stable from LOAD until leaving WAIT.
REQ-019 In WAIT, SHALL hold core_ce=1 and core_load=0 and increment the 7-bit counter each cycle.
REQ-020 In WAIT, if core_done=1, SHALL capture core_odat into out_data, set out_err=0, and go to OUT the next cycle.
REQ-021 In WAIT, if the counter reaches TIMEOUT-1 without core_done, SHALL set out_data=0 and out_err=1 and go to OUT.
REQ-022 If core_done and the timeout coincide, SHALL give core_done priority.
REQ-023 Nominal latency SHALL be 66 cycles from the LOAD cycle to out_valid (core 64 cycles, plus one cycle each for capture and registered out_valid).
REQ-024 SHALL drive core_ce=0 in IDLE, KEY, DATA and OUT.
REQ-025 In OUT, SHALL hold out_valid=1 with out_data/out_err stable until out_ready=1, then return to IDLE the following cycle.
REQ-026 SHALL ignore core_done when outside WAIT.
REQ-027 SHALL never accept an input word in the same cycle as an out handshake.
REQ-028 SHALL drive all outputs from registers.

Reset
REQ-029 On rst=1, SHALL go to IDLE and set in_ready=1, out_valid=0, out_err=0, out_data=0, core_load=0, core_ce=0, core_key=0, core_idat=0, key_loaded=0, and the word index and counter to 0.
REQ-030 Reset mid-job (any state) SHALL abandon the job with no output and require the full key again.

Structure
REQ-031 SHALL put state encodings, KEY_WORDS=3, DATA_WORDS=2 and the default TIMEOUT in shared package present_pkg.
REQ-032 SHALL be a single module with the decrypt core instantiated outside it by the parent; no sub-module is required.

Verification
REQ-033 Full job: words 0x00000000, 0x00000000, 0x00000000, 0x00000000, 0x00000000 with a core model returning 0x2844B365C06992A3 -> core_load one cycle with key=0 and idat=0; out_valid with out_data=0x2844B365C06992A3 and out_err=0.
REQ-034 key_reuse=1 with 2 words after the REQ-033 job -> exactly 2 words accepted, core_key unchanged, result returned.
REQ-035 key_reuse=1 immediately after reset -> treated as a key word and 5 words required.
REQ-036 Core model never asserts done -> out_valid after 96 WAIT cycles with out_err=1 and out_data=0.
REQ-037 out_ready held low for 10 cycles -> out_valid and out_data stable and in_ready=0 throughout; IDLE one cycle after the handshake.
REQ-038 rst asserted in WAIT -> core_ce=0 next cycle; no out_valid; a subsequent key_reuse=1 job requires the full key.

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT decrypt controller: FSM encoding and job geometry.
package present_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KEY,
      S_DATA,
      S_LOAD,
      S_WAIT,
      S_OUT
   } state_t;

   localparam int KEY_WORDS   = 3;
   localparam int DATA_WORDS  = 2;
   localparam int TIMEOUT_DEF = 96;

endpackage

// File: rtl/present_dec_ctrl.sv
// Collects an 80-bit key and 64-bit block from a 32-bit stream, runs an external
// PRESENT decrypt core, and returns the plaintext (or a timeout error) on a handshake.
module present_dec_ctrl
   import present_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        key_reuse,
   output logic        core_load,
   output logic        core_ce,
   output logic [79:0] core_key,
   output logic [63:0] core_idat,
   input  logic        core_done,
   input  logic [63:0] core_odat,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data,
   output logic        out_err
);

   state_t      state, state_nx;
   logic [1:0]  idx, idx_nx;
   logic [6:0]  cnt;
   logic        key_loaded;
   logic        in_acc, out_hs, timeout_hit, reuse_hit;

   assign in_acc      = in_valid && in_ready;
   assign out_hs      = out_valid && out_ready;
   assign timeout_hit = (cnt == 7'(TIMEOUT - 1));
   assign reuse_hit   = key_reuse && key_loaded;

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      case (state)
         S_IDLE: if (in_acc) begin
            state_nx = reuse_hit ? S_DATA : S_KEY;
            idx_nx   = 2'd1;
         end
         S_KEY: if (in_acc) begin
            if (idx == 2'(KEY_WORDS - 1)) begin
               state_nx = S_DATA;
               idx_nx   = 2'd0;
            end else begin
               idx_nx = idx + 2'd1;
            end
         end
         S_DATA: if (in_acc) begin
            if (idx == 2'(DATA_WORDS - 1)) begin
               state_nx = S_LOAD;
               idx_nx   = 2'd0;
            end else begin
               idx_nx = idx + 2'd1;
            end
         end
         S_LOAD: state_nx = S_WAIT;
         S_WAIT: if (core_done || timeout_hit) state_nx = S_OUT;
         S_OUT:  if (out_hs) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= 2'd0;
         cnt        <= 7'd0;
         key_loaded <= 1'b0;
         core_key   <= '0;
         core_idat  <= '0;
         out_data   <= '0;
         out_err    <= 1'b0;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         core_load  <= 1'b0;
         core_ce    <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;

         // Collection registers double as the core operands, so they stay
         // frozen once collection ends until the next job starts.
         if (in_acc) begin
            case (state)
               S_IDLE:
                  if (reuse_hit) core_idat[63:32] <= in_data;
                  else           core_key[79:48]  <= in_data;
               S_KEY:
                  if (idx == 2'd1) core_key[47:16] <= in_data;
                  else begin
                     core_key[15:0] <= in_data[15:0];
                     key_loaded     <= 1'b1;
                  end
               S_DATA:
                  if (idx == 2'd0) core_idat[63:32] <= in_data;
                  else             core_idat[31:0]  <= in_data;
               default: ;
            endcase
         end

         if (state == S_LOAD)      cnt <= 7'd0;
         else if (state == S_WAIT) cnt <= cnt + 7'd1;

         // core_done wins over a coinciding timeout
         if (state == S_WAIT) begin
            if (core_done) begin
               out_data <= core_odat;
               out_err  <= 1'b0;
            end else if (timeout_hit) begin
               out_data <= '0;
               out_err  <= 1'b1;
            end
         end

         // out_valid trails entry to OUT by one cycle, after the capture lands
         out_valid <= (state == S_OUT) && !out_hs;
         in_ready  <= (state_nx == S_IDLE) || (state_nx == S_KEY) || (state_nx == S_DATA);
         core_load <= (state_nx == S_LOAD);
         core_ce   <= (state_nx == S_LOAD) || (state_nx == S_WAIT);
      end
   end

endmodule

// File: tb/tb_present_dec_ctrl.sv
// Bench for present_dec_ctrl: table of jobs plus reset corner sequences, with a
// behavioural decrypt-core model and a result scoreboard.
module tb_present_dec_ctrl;

   localparam int TO      = 96;
   localparam int LAT_OK  = 66;
   localparam int LAT_TO  = TO + 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_data;
   logic        key_reuse;
   logic        core_load, core_ce;
   logic [79:0] core_key;
   logic [63:0] core_idat;
   logic        core_done;
   logic [63:0] core_odat;
   logic        out_valid, out_ready;
   logic [63:0] out_data;
   logic        out_err;

   present_dec_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .key_reuse(key_reuse),
      .core_load(core_load), .core_ce(core_ce), .core_key(core_key), .core_idat(core_idat),
      .core_done(core_done), .core_odat(core_odat),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             kr;
      logic [4:0][31:0] w;
      logic             done_en;
      logic [63:0]      odat;
      int               gap;
      int               hold;
   } job_t;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } res_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   res_t sb[$];

   // bench-side model of what the controller should have collected
   logic        mdl_loaded;
   logic [79:0] mdl_key;
   logic [63:0] mdl_idat;

   // decrypt core model: done 64 cycles after load, held until the next load
   int          m_cnt = 0;
   logic        m_done_en = 1'b0;
   logic [63:0] m_odat = '0;
   assign core_done = m_done_en && (m_cnt == 64);
   assign core_odat = m_odat;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (core_load)                   m_cnt <= 1;
      else if (m_cnt != 0 && m_cnt < 64) m_cnt <= m_cnt + 1;
   end

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // load monitor and operand-hold checks during the core run
   int          ld_cyc = 0;
   logic [79:0] ld_key = '0;
   logic [63:0] ld_idat = '0;
   logic        ld_prev = 1'b0;
   always @(negedge clk) begin
      if (core_load) begin
         chk("core_load single cycle", 80'(ld_prev), 80'(0));
         chk("core_ce with load", 80'(core_ce), 80'(1));
         ld_cyc  = cyc;
         ld_key  = core_key;
         ld_idat = core_idat;
      end else if (core_ce) begin
         chk("core_key held", core_key, ld_key);
         chk("core_idat held", 80'(core_idat), 80'(ld_idat));
      end
      ld_prev = core_load;
   end

   function automatic job_t mk(input logic kr, input logic [31:0] w0, w1, w2, w3, w4,
                               input logic de, input logic [63:0] od, input int gap, hold);
      job_t j;
      j.kr = kr; j.w = {w4, w3, w2, w1, w0};
      j.done_en = de; j.odat = od; j.gap = gap; j.hold = hold;
      return j;
   endfunction

   // caller is at a negedge; returns at a negedge
   task automatic send_job(input job_t j);
      logic reuse;
      int   nacc, t;
      res_t r;
      reuse = j.kr && mdl_loaded;
      nacc  = reuse ? 2 : 5;
      if (!reuse) mdl_key = {j.w[0], j.w[1], j.w[2][15:0]};
      mdl_idat   = reuse ? {j.w[0], j.w[1]} : {j.w[3], j.w[4]};
      mdl_loaded = 1'b1;
      r.data = j.done_en ? j.odat : 64'd0;
      r.err  = !j.done_en;
      sb.push_back(r);
      m_done_en = j.done_en;
      m_odat    = j.odat;
      for (int i = 0; i < nacc; i++) begin
         in_valid  = 1'b1;
         in_data   = j.w[i];
         key_reuse = j.kr;
         t = 0;
         while (!in_ready && t < 20) begin @(negedge clk); t++; end
         if (t >= 20) chk("in_ready timeout", 80'(in_ready), 80'(1));
         @(posedge clk);
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("in_ready after word %0d", i), 80'(in_ready), 80'(i < nacc - 1));
         if (i < nacc - 1) repeat (j.gap) @(negedge clk);
      end
   endtask

   task automatic get_result(input job_t j);
      int   t;
      res_t r;
      logic [63:0] d0;
      t = 0;
      while (!out_valid && t < 200) begin @(negedge clk); t++; end
      if (!out_valid) begin
         chk("out_valid timeout", 80'(out_valid), 80'(1));
         return;
      end
      chk("latency", 80'(cyc - ld_cyc), 80'(j.done_en ? LAT_OK : LAT_TO));
      chk("core_key at load", ld_key, mdl_key);
      chk("core_idat at load", 80'(ld_idat), 80'(mdl_idat));
      if (sb.size() == 0) begin
         chk("scoreboard empty", 80'(0), 80'(1));
         return;
      end
      r = sb.pop_front();
      chk("out_data", 80'(out_data), 80'(r.data));
      chk("out_err", 80'(out_err), 80'(r.err));
      d0 = out_data;
      repeat (j.hold) begin
         @(negedge clk);
         chk("hold out_valid", 80'(out_valid), 80'(1));
         chk("hold out_data", 80'(out_data), 80'(d0));
         chk("hold in_ready", 80'(in_ready), 80'(0));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid after hs", 80'(out_valid), 80'(0));
      chk("in_ready after hs", 80'(in_ready), 80'(1));
   endtask

   job_t tab[4];
   job_t jx;

   initial begin
      int t;
      logic seen;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; key_reuse = 1'b0; out_ready = 1'b0;
      mdl_loaded = 1'b0; mdl_key = '0; mdl_idat = '0;

      tab[0] = mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 64'h2844B365C06992A3, 0, 0);
      tab[1] = mk(1'b1, 32'hDEADBEEF, 32'h01234567, 32'h0, 32'h0, 32'h0,
                  1'b1, 64'h0123456789ABCDEF, 0, 10);
      tab[2] = mk(1'b0, 32'h11111111, 32'h22222222, 32'h3333ABCD, 32'h44444444, 32'h55555555,
                  1'b0, 64'hA5A5A5A5A5A5A5A5, 0, 2);
      tab[3] = mk(1'b1, 32'hCAFEF00D, 32'h87654321, 32'h0, 32'h0, 32'h0,
                  1'b1, 64'hFEDCBA9876543210, 2, 0);

      repeat (3) @(negedge clk);
      chk("rst in_ready", 80'(in_ready), 80'(1));
      chk("rst out_valid", 80'(out_valid), 80'(0));
      chk("rst out_err", 80'(out_err), 80'(0));
      chk("rst out_data", 80'(out_data), 80'(0));
      chk("rst core_load", 80'(core_load), 80'(0));
      chk("rst core_ce", 80'(core_ce), 80'(0));
      chk("rst core_key", core_key, 80'(0));
      chk("rst core_idat", 80'(core_idat), 80'(0));
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         send_job(tab[i]);
         get_result(tab[i]);
         @(negedge clk);
      end

      // key_reuse straight after reset must still collect a full key
      rst = 1'b1; @(negedge clk); rst = 1'b0; mdl_loaded = 1'b0;
      jx = mk(1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h12345678, 32'h9ABCDEF0, 32'h13579BDF,
              1'b1, 64'h1122334455667788, 0, 0);
      send_job(jx);
      get_result(jx);
      @(negedge clk);

      // reset during WAIT abandons the job
      jx = mk(1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004, 32'hEEEE0005,
              1'b1, 64'h0BADF00D0BADF00D, 0, 0);
      send_job(jx);
      t = 0;
      while (!(core_ce && !core_load) && t < 10) begin @(negedge clk); t++; end
      chk("reached WAIT", 80'(core_ce && !core_load), 80'(1));
      repeat (5) @(negedge clk);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      void'(sb.pop_back());
      mdl_loaded = 1'b0;
      chk("abort core_ce", 80'(core_ce), 80'(0));
      chk("abort in_ready", 80'(in_ready), 80'(1));
      seen = 1'b0;
      repeat (100) begin @(negedge clk); seen |= out_valid; end
      chk("abort no out_valid", 80'(seen), 80'(0));
      jx = mk(1'b1, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505,
              1'b1, 64'hDEADBEEFCAFEBABE, 1, 0);
      send_job(jx);
      get_result(jx);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
